// File: rtl/jt51_kon_queue.sv
// jt51_kon_queue: key-on request queue in front of jt51_kon.
// CPU writes to reg 0x08 are buffered and each one is held for a full slot round.
//
// Ports:
//   clk, rst (async, active high), cen (slot enable)
//   write, a0, din[7:0]  : CPU bus (a0=0 address, a0=1 data)
//   keyon_op[3:0]        : operator mask {S4,S2,S3,S1} of current request
//   keyon_ch[2:0]        : channel of current request
//   up_keyon             : high while the current request is applied
//   busy                 : queue non-empty or request in flight
//   ovf                  : sticky overflow flag
//
// Optional feature macro: JT51_KONQ_OVF_EN enables the ovf flag;
// when it is undefined ovf is tied low and full pushes are silently dropped.

module jt51_kon_queue #(
    parameter int DEPTH = 4,
    parameter int HOLD  = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic       write,
    input  logic       a0,
    input  logic [7:0] din,
    output logic [3:0] keyon_op,
    output logic [2:0] keyon_ch,
    output logic       up_keyon,
    output logic       busy,
    output logic       ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(HOLD);

    typedef enum logic {ST_IDLE, ST_HOLD} state_t;

    state_t          st_q, st_d;
    logic [7:0]      sel_addr;
    logic [6:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            up_d;
    logic            pop, do_pop;
    logic            push_req, push_ok;
    logic            empty, full;

    assign push_req = write & a0 & (sel_addr == 8'h08);
    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign do_pop   = cen & pop;
    // A pop on the same edge frees a slot, so a full queue still accepts.
    assign push_ok  = push_req & (~full | do_pop);
    assign busy     = ~empty | up_keyon;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sel_addr <= 8'h00;
        else if (write && !a0)
            sel_addr <= din;
    end

    // {din[6:3], din[2:0]} packs as din[6:0]
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= din[6:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            unique case ({push_ok, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        st_d  = st_q;
        cnt_d = cnt_q;
        up_d  = up_keyon;
        pop   = 1'b0;
        unique case (st_q)
            ST_IDLE: begin
                if (!empty) begin
                    pop   = 1'b1;
                    up_d  = 1'b1;
                    cnt_d = CW'(HOLD - 1);
                    st_d  = ST_HOLD;
                end else begin
                    up_d = 1'b0;
                end
            end
            ST_HOLD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!empty) begin
                    // chain straight into the next request, no idle slot
                    pop   = 1'b1;
                    cnt_d = CW'(HOLD - 1);
                end else begin
                    up_d = 1'b0;
                    st_d = ST_IDLE;
                end
            end
            default: begin
                st_d = ST_IDLE;
                up_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q     <= ST_IDLE;
            cnt_q    <= '0;
            up_keyon <= 1'b0;
            keyon_op <= 4'h0;
            keyon_ch <= 3'h0;
        end else if (cen) begin
            st_q     <= st_d;
            cnt_q    <= cnt_d;
            up_keyon <= up_d;
            if (pop) begin
                keyon_op <= mem[rd_ptr][6:3];
                keyon_ch <= mem[rd_ptr][2:0];
            end
        end
    end

`ifdef JT51_KONQ_OVF_EN
    logic drop, clr;

    assign drop = push_req & full & ~do_pop;
    // writing 0x00 to reg 0x08 acknowledges the overflow
    assign clr  = push_req & (din == 8'h00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ovf <= 1'b0;
        else if (drop)
            ovf <= 1'b1;
        else if (clr)
            ovf <= 1'b0;
    end
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_jt51_kon_queue.sv
// tb_jt51_kon_queue: directed + random check of jt51_kon_queue
// against a queue-based request model.

module tb_jt51_kon_queue;

    localparam int DEPTH = 4;
    localparam int HOLD  = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cen = 1'b0;
    logic       write = 1'b0;
    logic       a0 = 1'b0;
    logic [7:0] din = 8'h00;
    logic [3:0] keyon_op;
    logic [2:0] keyon_ch;
    logic       up_keyon;
    logic       busy;
    logic       ovf;

    int total = 0;
    int bad   = 0;

    jt51_kon_queue #(.DEPTH(DEPTH), .HOLD(HOLD)) dut (
        .clk      (clk),
        .rst      (rst),
        .cen      (cen),
        .write    (write),
        .a0       (a0),
        .din      (din),
        .keyon_op (keyon_op),
        .keyon_ch (keyon_ch),
        .up_keyon (up_keyon),
        .busy     (busy),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    // Reference: pending requests, current request, cen ticks left on it.
    logic [6:0] q[$];
    logic [6:0] cur;
    int         rem;
    logic [7:0] sel;
    logic       movf;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            cur  = 7'h0;
            rem  = 0;
            sel  = 8'h00;
            movf = 1'b0;
        end else begin
            if (cen) begin
                if (rem > 1)
                    rem = rem - 1;
                else if (q.size() > 0) begin
                    cur = q.pop_front();
                    rem = HOLD;
                end else
                    rem = 0;
            end
            if (write && !a0)
                sel = din;
            else if (write && sel == 8'h08) begin
                if (q.size() < DEPTH) begin
                    q.push_back(din[6:0]);
`ifdef JT51_KONQ_OVF_EN
                    if (din == 8'h00) movf = 1'b0;
`endif
                end else begin
`ifdef JT51_KONQ_OVF_EN
                    movf = 1'b1;
`endif
                end
            end
        end
    end

    task automatic expect_eq(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        expect_eq("up_keyon", up_keyon, rem > 0);
        expect_eq("keyon_op", keyon_op, cur[6:3]);
        expect_eq("keyon_ch", keyon_ch, cur[2:0]);
        expect_eq("busy", busy, (q.size() > 0) || (rem > 0));
        expect_eq("ovf", ovf, movf);
    endtask

    task automatic tick(input logic w, input logic a, input logic [7:0] d,
                        input logic c);
        write = w;
        a0    = a;
        din   = d;
        cen   = c;
        @(posedge clk);
        @(negedge clk);
        write = 1'b0;
        check_all();
    endtask

    int n;
    logic exp_ovf;

    initial begin
`ifdef JT51_KONQ_OVF_EN
        exp_ovf = 1'b1;
`else
        exp_ovf = 1'b0;
`endif
        @(negedge clk);
        @(negedge clk);
        check_all();
        expect_eq("rst_up", up_keyon, 0);
        expect_eq("rst_busy", busy, 0);
        rst = 1'b0;

        // 1: single request 0x79
        tick(1, 0, 8'h08, 1);
        tick(1, 1, 8'h79, 1);
        expect_eq("t1_lat", up_keyon, 0);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick(0, 0, 8'h00, 1);
            if (i == 0) begin
                expect_eq("t1_op", keyon_op, 4'hF);
                expect_eq("t1_ch", keyon_ch, 3'h1);
            end
            if (up_keyon) n++;
        end
        expect_eq("t1_len", n, 32);
        expect_eq("t1_busy", busy, 0);
        expect_eq("t1_hold_op", keyon_op, 4'hF);

        // 2: five back-to-back requests
        tick(1, 1, 8'h08, 1);
        for (int i = 9; i <= 12; i++)
            tick(1, 1, 8'(i), 1);
        n = 4;
        for (int i = 0; i < 200; i++) begin
            tick(0, 0, 8'h00, 1);
            if (up_keyon) n++;
        end
        expect_eq("t2_len", n, 160);
        expect_eq("t2_last_ch", keyon_ch, 3'h4);

        // 3: overflow and its clearing write
        for (int i = 0; i < 6; i++)
            tick(1, 1, 8'h10 + 8'(i), 1);
        expect_eq("t3_ovf", ovf, exp_ovf);
        for (int i = 0; i < 200; i++)
            tick(0, 0, 8'h00, 1);
        expect_eq("t3_ovf_hold", ovf, exp_ovf);
        tick(1, 1, 8'h00, 1);
        expect_eq("t3_ovf_clr", ovf, 0);
        for (int i = 0; i < 40; i++)
            tick(0, 0, 8'h00, 1);

        // 4: cen every third clk
        tick(1, 1, 8'h23, 1);
        n = 0;
        for (int i = 0; i < 150; i++) begin
            tick(0, 0, 8'h00, (i % 3) == 2);
            if (up_keyon) n++;
        end
        expect_eq("t4_clks", n, 96);

        // 5: data to another register
        tick(1, 0, 8'h20, 1);
        tick(1, 1, 8'h78, 1);
        tick(0, 0, 8'h00, 1);
        expect_eq("t5_busy", busy, 0);
        tick(0, 0, 8'h00, 1);
        expect_eq("t5_up", up_keyon, 0);

        // 6: reset mid-hold with two pending
        tick(1, 0, 8'h08, 1);
        tick(1, 1, 8'h31, 1);
        tick(1, 1, 8'h42, 1);
        tick(1, 1, 8'h53, 1);
        for (int i = 0; i < 5; i++)
            tick(0, 0, 8'h00, 1);
        rst = 1'b1;
        #1;
        check_all();
        expect_eq("t6_up", up_keyon, 0);
        expect_eq("t6_busy", busy, 0);
        expect_eq("t6_op", keyon_op, 0);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick(0, 0, 8'h00, 1);
            if (up_keyon) n++;
        end
        expect_eq("t6_replay", n, 0);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            logic w, a, c;
            logic [7:0] d;
            w = ($urandom % 6) == 0;
            a = ($urandom % 5) != 0;
            c = ($urandom % 3) != 0;
            if (!a)
                d = (($urandom % 4) == 0) ? 8'($urandom) : 8'h08;
            else
                d = (($urandom % 8) == 0) ? 8'h00 : 8'($urandom);
            tick(w, a, d, c);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
